vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 77 +++++++
 tb/tb_vga_sync_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing from a divided master clock
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_PIXELS = 640,
  parameter int H_FP     = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BP     = 48,
  parameter int V_PIXELS = 480,
  parameter int V_FP     = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_N_In,
  output logic       Pixel_Tick_Out,
  output logic       HSync_Out,
  output logic       VSync_Out,
  output logic       Disp_Ena_Out,
  output logic [9:0] Val_Row_Out,
  output logic [9:0] Val_Col_Out,
  output logic       Frame_Start_Out
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_PIXELS + H_FP + H_PULSE + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_PIXELS + V_FP + V_PULSE + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_PIXELS);
  localparam logic [9:0] V_ACT  = 10'(V_PIXELS);
  localparam logic [9:0] HS_S   = 10'(H_PIXELS + H_FP);
  localparam logic [9:0] HS_E   = 10'(H_PIXELS + H_FP + H_PULSE - 1);
  localparam logic [9:0] VS_S   = 10'(V_PIXELS + V_FP);
  localparam logic [9:0] VS_E   = 10'(V_PIXELS + V_FP + V_PULSE - 1);
  logic [DW-1:0] div;
  logic          tick;
  logic          row_wrap;
  logic [9:0]    row_nxt;
  logic [9:0]    col_nxt;
  // next counter values; decode is taken from these so outputs align with the counters
  always_comb begin
    tick     = div == DIV_LAST;
    row_wrap = Val_Row_Out == H_LAST;
    row_nxt  = row_wrap ? '0 : Val_Row_Out + 10'd1;
    col_nxt  = row_wrap ? ((Val_Col_Out == V_LAST) ? '0 : Val_Col_Out + 10'd1) : Val_Col_Out;
  end
  // master-clock divider and registered one-cycle pixel tick
  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      div            <= '0;
      Pixel_Tick_Out <= 1'b0;
    end else begin
      div            <= tick ? '0 : div + DW'(1);
      Pixel_Tick_Out <= tick;
    end
  end
  // counters and decoded timing, reset parks at the last pixel so the first tick lands on (0,0)
  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      Val_Row_Out     <= H_LAST;
      Val_Col_Out     <= V_LAST;
      HSync_Out       <= ~H_POL;
      VSync_Out       <= ~V_POL;
      Disp_Ena_Out    <= 1'b0;
      Frame_Start_Out <= 1'b0;
    end else begin
      Frame_Start_Out <= tick && row_nxt == '0 && col_nxt == '0;
      if (tick) begin
        Val_Row_Out  <= row_nxt;
        Val_Col_Out  <= col_nxt;
        HSync_Out    <= (row_nxt >= HS_S && row_nxt <= HS_E) ? H_POL : ~H_POL;
        VSync_Out    <= (col_nxt >= VS_S && col_nxt <= VS_E) ? V_POL : ~V_POL;
        Disp_Ena_Out <= row_nxt < H_ACT && col_nxt < V_ACT;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of VGA timing, default instance plus a fast short-frame instance
module tb_vga_sync_gen;
  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic       a_pt, a_hs, a_vs, a_de, a_fs;
  logic [9:0] a_row, a_col;
  logic       b_pt, b_hs, b_vs, b_de, b_fs;
  logic [9:0] b_row, b_col;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  vga_sync_gen u_a (
    .Master_Clock_In(clk), .Reset_N_In(rst_a), .Pixel_Tick_Out(a_pt),
    .HSync_Out(a_hs), .VSync_Out(a_vs), .Disp_Ena_Out(a_de),
    .Val_Row_Out(a_row), .Val_Col_Out(a_col), .Frame_Start_Out(a_fs)
  );
  vga_sync_gen #(.CLK_DIV(2), .V_PIXELS(4), .V_FP(2), .V_PULSE(2), .V_BP(2)) u_b (
    .Master_Clock_In(clk), .Reset_N_In(rst_b), .Pixel_Tick_Out(b_pt),
    .HSync_Out(b_hs), .VSync_Out(b_vs), .Disp_Ena_Out(b_de),
    .Val_Row_Out(b_row), .Val_Col_Out(b_col), .Frame_Start_Out(b_fs)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic next_tick(input bit b, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(b ? b_pt : a_pt) && cyc < 16);
    chk("tick_seen", b ? b_pt : a_pt, 1);
  endtask
  task automatic run_to(input bit b, input int r, input int c);
    int n = 0;
    int cy;
    while (!((b ? b_row : a_row) == 10'(r) && (b ? b_col : a_col) == 10'(c)) && n < 10000) begin
      next_tick(b, cy);
      n++;
    end
    chk($sformatf("reach_%0d_%0d", r, c), b ? b_row : a_row, r);
  endtask
  initial begin
    int cy, n, cycles, hsl, vsl, del;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_row", a_row, 799);
    chk("rst_col", a_col, 524);
    chk("rst_hs", a_hs, 1);
    chk("rst_vs", a_vs, 1);
    chk("rst_de", a_de, 0);
    chk("rst_fs", a_fs, 0);
    chk("rst_pt", a_pt, 0);
    chk("rst_b_col", b_col, 9);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_tick_pt", a_pt, 0);
    chk("pre_tick_row", a_row, 799);
    @(negedge clk);
    chk("first_row", a_row, 0);
    chk("first_col", a_col, 0);
    chk("first_de", a_de, 1);
    chk("first_fs", a_fs, 1);
    chk("first_pt", a_pt, 1);
    chk("first_hs", a_hs, 1);
    chk("first_vs", a_vs, 1);
    @(negedge clk);
    chk("fs_width", a_fs, 0);
    chk("pt_width", a_pt, 0);
    chk("row_hold", a_row, 0);
    repeat (2) begin
      @(negedge clk);
      chk("pt_gap", a_pt, 0);
    end
    @(negedge clk);
    chk("pt_period", a_pt, 1);
    chk("second_row", a_row, 1);
    run_to(0, 639, 0);
    chk("de_639", a_de, 1);
    next_tick(0, cy);
    chk("row_640", a_row, 640);
    chk("de_640", a_de, 0);
    hsl = 0;
    del = 0;
    repeat (800) begin
      next_tick(0, cy);
      if (!a_hs) hsl++;
      if (a_de) del++;
    end
    chk("hs_low_ticks", hsl, 96);
    chk("de_line_ticks", del, 640);
    chk("line_row", a_row, 640);
    chk("line_col", a_col, 1);
    run_to(0, 655, 1);
    chk("hs_655", a_hs, 1);
    next_tick(0, cy);
    chk("hs_656", a_hs, 0);
    run_to(0, 751, 1);
    chk("hs_751", a_hs, 0);
    next_tick(0, cy);
    chk("hs_752", a_hs, 1);
    run_to(0, 799, 1);
    chk("col_799", a_col, 1);
    next_tick(0, cy);
    chk("wrap_row", a_row, 0);
    chk("wrap_col", a_col, 2);
    chk("wrap_fs", a_fs, 0);
    chk("wrap_de", a_de, 1);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_pre_pt", b_pt, 0);
    chk("b_pre_row", b_row, 799);
    @(negedge clk);
    chk("b_first_row", b_row, 0);
    chk("b_first_col", b_col, 0);
    chk("b_first_fs", b_fs, 1);
    chk("b_first_pt", b_pt, 1);
    n = 0;
    cycles = 0;
    vsl = 0;
    del = 0;
    do begin
      next_tick(1, cy);
      n++;
      cycles += cy;
      if (!b_vs) vsl++;
      if (b_de) del++;
    end while (!b_fs && n < 9000);
    chk("frame_ticks", n, 8000);
    chk("frame_cycles", cycles, 16000);
    chk("vs_low_ticks", vsl, 1600);
    chk("de_frame_ticks", del, 2560);
    chk("frame_row", b_row, 0);
    chk("frame_col", b_col, 0);
    run_to(1, 300, 2);
    chk("mid_de", b_de, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_row", b_row, 799);
    chk("mid_rst_col", b_col, 9);
    chk("mid_rst_de", b_de, 0);
    chk("mid_rst_pt", b_pt, 0);
    chk("mid_rst_fs", b_fs, 0);
    chk("mid_rst_hs", b_hs, 1);
    chk("mid_rst_vs", b_vs, 1);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("re_pre_row", b_row, 799);
    @(negedge clk);
    chk("re_row", b_row, 0);
    chk("re_col", b_col, 0);
    chk("re_fs", b_fs, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
